// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster timing constants and the coordinate type used by
// the timing generator and every downstream renderer.
package vga_timing_pkg;

    localparam int unsigned COORD_W   = 32'd10;

    localparam int unsigned H_VISIBLE = 32'd640;
    localparam int unsigned H_FP      = 32'd16;
    localparam int unsigned H_SYNC    = 32'd96;
    localparam int unsigned H_BP      = 32'd48;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam int unsigned V_VISIBLE = 32'd480;
    localparam int unsigned V_FP      = 32'd10;
    localparam int unsigned V_SYNC    = 32'd2;
    localparam int unsigned V_BP      = 32'd33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    typedef logic [COORD_W-1:0] coord_t;

    localparam coord_t COORD_ZERO = 10'd0;
    localparam coord_t COORD_ONE  = 10'd1;

    // Half-open window test [lo, hi) on unsigned coordinates.
    function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus look-ahead decode of the
// visible and sync windows from the value the counter is about to take.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL      = H_TOTAL,
    parameter int unsigned VISIBLE    = H_VISIBLE,
    parameter int unsigned SYNC_START = H_VISIBLE + H_FP,
    parameter int unsigned SYNC_END   = H_VISIBLE + H_FP + H_SYNC
)(
    input  logic   clk,
    input  logic   reset,
    input  logic   adv,
    output logic   wrap_out,
    output coord_t count,
    output coord_t next_count,
    output logic   active,
    output logic   sync_n
);

    localparam coord_t LAST_C       = coord_t'(TOTAL - 32'd1);
    localparam coord_t VISIBLE_C    = coord_t'(VISIBLE);
    localparam coord_t SYNC_START_C = coord_t'(SYNC_START);
    localparam coord_t SYNC_END_C   = coord_t'(SYNC_END);

    coord_t count_r;
    coord_t next_s;
    logic   wrap_s;

    // Next position; reset parks the counter on its last value so the first
    // advance after release lands on zero.
    always_comb begin
        next_s = count_r;
        wrap_s = 1'b0;
        if (reset) begin
            next_s = LAST_C;
        end else if (adv) begin
            if (count_r == LAST_C) begin
                next_s = COORD_ZERO;
                wrap_s = 1'b1;
            end else begin
                next_s = count_r + COORD_ONE;
            end
        end else begin
            next_s = count_r;
        end
    end

    // Position register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= LAST_C;
        end else begin
            count_r <= next_s;
        end
    end

    assign wrap_out   = wrap_s;
    assign count      = count_r;
    assign next_count = next_s;
    assign active     = (next_s < VISIBLE_C);
    assign sync_n     = ~in_window(next_s, SYNC_START_C, SYNC_END_C);

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster generator: registered coordinates, blanking, syncs,
// line/frame markers and a completed-frame counter, all mutually coherent.
module vga_timing_gen
    import vga_timing_pkg::coord_t;
    import vga_timing_pkg::COORD_ZERO;
#(
    parameter int unsigned H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int unsigned H_FP      = vga_timing_pkg::H_FP,
    parameter int unsigned H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BP      = vga_timing_pkg::H_BP,
    parameter int unsigned V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int unsigned V_FP      = vga_timing_pkg::V_FP,
    parameter int unsigned V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BP      = vga_timing_pkg::V_BP,
    parameter int unsigned FCNT_W    = 32'd16
)(
    input  logic              vga_clk,
    input  logic              reset,
    output coord_t            DrawX,
    output coord_t            DrawY,
    output logic              blank,
    output logic              hs,
    output logic              vs,
    output logic              line_start,
    output logic              frame_start,
    output logic [FCNT_W-1:0] frame_count
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam logic [FCNT_W-1:0] FCNT_ONE = {{(FCNT_W-1){1'b0}}, 1'b1};

    if (H_TOTAL > 32'd1024) begin : g_h_range
        $error("vga_timing_gen: H_TOTAL exceeds the 10-bit coordinate range");
    end
    if (V_TOTAL > 32'd1024) begin : g_v_range
        $error("vga_timing_gen: V_TOTAL exceeds the 10-bit coordinate range");
    end

    logic   h_wrap_s, h_active_s, h_sync_n_s;
    logic   v_wrap_s, v_active_s, v_sync_n_s;
    coord_t h_count_s, h_next_s;
    coord_t v_count_s, v_next_s;

    logic              blank_r;
    logic              hs_r;
    logic              vs_r;
    logic              line_start_r;
    logic              frame_start_r;
    logic [FCNT_W-1:0] frame_count_r;
    logic              started_r;
    logic              frame_wrap_s;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .VISIBLE    (H_VISIBLE),
        .SYNC_START (H_VISIBLE + H_FP),
        .SYNC_END   (H_VISIBLE + H_FP + H_SYNC)
    ) u_h_axis (
        .clk        (vga_clk),
        .reset      (reset),
        .adv        (1'b1),
        .wrap_out   (h_wrap_s),
        .count      (h_count_s),
        .next_count (h_next_s),
        .active     (h_active_s),
        .sync_n     (h_sync_n_s)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .VISIBLE    (V_VISIBLE),
        .SYNC_START (V_VISIBLE + V_FP),
        .SYNC_END   (V_VISIBLE + V_FP + V_SYNC)
    ) u_v_axis (
        .clk        (vga_clk),
        .reset      (reset),
        .adv        (h_wrap_s),
        .wrap_out   (v_wrap_s),
        .count      (v_count_s),
        .next_count (v_next_s),
        .active     (v_active_s),
        .sync_n     (v_sync_n_s)
    );

    // v_wrap_s is only raised on a horizontal wrap, so this marks the last pixel.
    assign frame_wrap_s = h_wrap_s & v_wrap_s;

    // Output registers decoded from the next coordinates; the wrap that merely
    // leaves the reset parking position is not a completed frame.
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            blank_r       <= 1'b0;
            hs_r          <= 1'b1;
            vs_r          <= 1'b1;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
            frame_count_r <= {FCNT_W{1'b0}};
            started_r     <= 1'b0;
        end else begin
            blank_r       <= h_active_s & v_active_s;
            hs_r          <= h_sync_n_s;
            vs_r          <= v_sync_n_s;
            line_start_r  <= (h_next_s == COORD_ZERO);
            frame_start_r <= (h_next_s == COORD_ZERO) && (v_next_s == COORD_ZERO);
            started_r     <= 1'b1;
            if (frame_wrap_s && started_r) begin
                frame_count_r <= frame_count_r + FCNT_ONE;
            end else begin
                frame_count_r <= frame_count_r;
            end
        end
    end

    assign DrawX       = h_count_s;
    assign DrawY       = v_count_s;
    assign blank       = blank_r;
    assign hs          = hs_r;
    assign vs          = vs_r;
    assign line_start  = line_start_r;
    assign frame_start = frame_start_r;
    assign frame_count = frame_count_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size 640x480 instance and a shrunken
// instance (25x15 raster, 4-bit frame counter) share clock and reset.
module tb_vga_timing_gen;

    typedef struct packed {
        int x; int y; bit blank; bit hs; bit vs; bit ls; bit fs; int fc;
    } obs_t;

    typedef struct packed {
        int x; int y; int fc; bit started;
    } mst_t;

    typedef struct packed {
        int hv; int hss; int hse; int ht; int vv; int vss; int vse; int vt; int fmod;
    } geo_t;

    typedef struct packed {
        bit rst; int n; obs_t exp;
    } vec_t;

    localparam geo_t GF = '{640, 656, 752, 800, 480, 490, 492, 525, 65536};
    localparam geo_t GS = '{16, 18, 22, 25, 8, 10, 12, 15, 16};

    logic        vga_clk;
    logic        reset;
    logic [9:0]  fx, fy, sx, sy;
    logic        fblank, fhs, fvs, fls, ffs;
    logic        sblank, shs, svs, sls, sfs;
    logic [15:0] fcnt_f;
    logic [3:0]  fcnt_s;

    int   checks   = 0;
    int   failures = 0;
    int   edges    = 0;
    mst_t ms_f, ms_s;
    obs_t q_f[$];
    obs_t q_s[$];
    vec_t tbl [14];

    vga_timing_gen dut_full (
        .vga_clk(vga_clk), .reset(reset), .DrawX(fx), .DrawY(fy), .blank(fblank),
        .hs(fhs), .vs(fvs), .line_start(fls), .frame_start(ffs), .frame_count(fcnt_f)
    );

    vga_timing_gen #(
        .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VISIBLE(8),  .V_FP(2), .V_SYNC(2), .V_BP(3), .FCNT_W(4)
    ) dut_small (
        .vga_clk(vga_clk), .reset(reset), .DrawX(sx), .DrawY(sy), .blank(sblank),
        .hs(shs), .vs(svs), .line_start(sls), .frame_start(sfs), .frame_count(fcnt_s)
    );

    initial vga_clk = 1'b0;
    always #20 vga_clk = ~vga_clk;

    function automatic mst_t m_next(input mst_t s, input bit rst, input geo_t g);
        mst_t n = s;
        if (rst) begin
            n.x = g.ht - 1; n.y = g.vt - 1; n.fc = 0; n.started = 1'b0;
        end else begin
            if (s.x == g.ht - 1) begin
                n.x = 0;
                if (s.y == g.vt - 1) begin
                    n.y = 0;
                    if (s.started) n.fc = (s.fc + 1) % g.fmod;
                end else begin
                    n.y = s.y + 1;
                end
            end else begin
                n.x = s.x + 1;
            end
            n.started = 1'b1;
        end
        return n;
    endfunction

    function automatic obs_t m_obs(input mst_t s, input geo_t g);
        obs_t o;
        o.x = s.x; o.y = s.y; o.fc = s.fc;
        o.blank = (s.x < g.hv) && (s.y < g.vv);
        o.hs = !((s.x >= g.hss) && (s.x < g.hse));
        o.vs = !((s.y >= g.vss) && (s.y < g.vse));
        o.ls = (s.x == 0);
        o.fs = (s.x == 0) && (s.y == 0);
        return o;
    endfunction

    function automatic obs_t obs_full();
        obs_t o;
        o.x = int'(fx); o.y = int'(fy); o.blank = fblank; o.hs = fhs; o.vs = fvs;
        o.ls = fls; o.fs = ffs; o.fc = int'(fcnt_f);
        return o;
    endfunction

    function automatic obs_t obs_small();
        obs_t o;
        o.x = int'(sx); o.y = int'(sy); o.blank = sblank; o.hs = shs; o.vs = svs;
        o.ls = sls; o.fs = sfs; o.fc = int'(fcnt_s);
        return o;
    endfunction

    task automatic cmp_obs(input string name, input obs_t a, input obs_t e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s edge=%0d: got (x=%0d y=%0d blank=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d) expected (x=%0d y=%0d blank=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d)",
                     name, edges, a.x, a.y, a.blank, a.hs, a.vs, a.ls, a.fs, a.fc,
                     e.x, e.y, e.blank, e.hs, e.vs, e.ls, e.fs, e.fc);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s edge=%0d: got %0d expected %0d", name, edges, got, exp);
        end
    endtask

    // Drive one edge: model predictions go to the scoreboards, DUTs are
    // sampled on the following falling edge.
    task automatic step(input bit rst);
        reset = rst;
        ms_f = m_next(ms_f, rst, GF);
        ms_s = m_next(ms_s, rst, GS);
        q_f.push_back(m_obs(ms_f, GF));
        q_s.push_back(m_obs(ms_s, GS));
        @(posedge vga_clk);
        @(negedge vga_clk);
        edges++;
        cmp_obs("sb_full", obs_full(), q_f.pop_front());
        cmp_obs("sb_small", obs_small(), q_s.pop_front());
    endtask

    initial begin
        int hs_low, vs_low, ls_cnt, fs_cnt;
        reset = 1'b1;
        ms_f = '0;
        ms_s = '0;

        //            rst   n     x    y    blk  hs   vs   ls   fs   fc
        tbl[0]  = '{1'b1, 3,   '{799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0}};
        tbl[1]  = '{1'b0, 1,   '{0,   0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0}};
        tbl[2]  = '{1'b0, 1,   '{1,   0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0}};
        tbl[3]  = '{1'b0, 638, '{639, 0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0}};
        tbl[4]  = '{1'b0, 1,   '{640, 0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0}};
        tbl[5]  = '{1'b0, 16,  '{656, 0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0}};
        tbl[6]  = '{1'b0, 95,  '{751, 0,   1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0}};
        tbl[7]  = '{1'b0, 1,   '{752, 0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0}};
        tbl[8]  = '{1'b0, 47,  '{799, 0,   1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0}};
        tbl[9]  = '{1'b0, 1,   '{0,   1,   1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0}};
        tbl[10] = '{1'b0, 300, '{300, 1,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0}};
        tbl[11] = '{1'b1, 1,   '{799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0}};
        tbl[12] = '{1'b1, 2,   '{799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0}};
        tbl[13] = '{1'b0, 1,   '{0,   0,   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0}};

        for (int i = 0; i < 14; i++) begin
            for (int k = 0; k < tbl[i].n; k++) step(tbl[i].rst);
            cmp_obs($sformatf("vec%0d", i), obs_full(), tbl[i].exp);
        end

        // Small raster: one full frame from (0,0).
        hs_low = 0; vs_low = 0; ls_cnt = 0; fs_cnt = 0;
        for (int k = 0; k < 375; k++) begin
            step(1'b0);
            if (!shs) hs_low++;
            if (!svs) vs_low++;
            if (sls) ls_cnt++;
            if (sfs) fs_cnt++;
        end
        chk_int("small_hs_low_cycles", hs_low, 60);
        chk_int("small_vs_low_cycles", vs_low, 50);
        chk_int("small_line_starts", ls_cnt, 15);
        chk_int("small_frame_starts", fs_cnt, 1);
        chk_int("small_frame1_fc", int'(fcnt_s), 1);
        chk_int("small_frame1_fs", int'(sfs), 1);

        // Small raster: reset in the visible area mid-frame.
        for (int k = 0; k < 135; k++) step(1'b0);
        chk_int("mid_x", int'(sx), 10);
        chk_int("mid_y", int'(sy), 5);
        chk_int("mid_blank", int'(sblank), 1);
        step(1'b1);
        cmp_obs("mid_reset", obs_small(), '{24, 14, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0});
        step(1'b0);
        cmp_obs("mid_release", obs_small(), '{0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0});

        // Small raster: 17 frames, counter wraps through 0 back to 1.
        fs_cnt = 0;
        for (int k = 0; k < 17 * 375; k++) begin
            step(1'b0);
            if (sfs) begin
                fs_cnt++;
                chk_int("wrap_fc_at_fs", int'(fcnt_s), fs_cnt % 16);
            end
        end
        chk_int("wrap_frame_starts", fs_cnt, 17);
        chk_int("wrap_final_fc", int'(fcnt_s), 1);

        // Full raster: one line of hsync from a fresh start.
        step(1'b1);
        step(1'b0);
        hs_low = 0;
        for (int k = 0; k < 800; k++) begin
            step(1'b0);
            if (!fhs) hs_low++;
        end
        chk_int("full_hs_low_cycles", hs_low, 96);
        chk_int("full_line1_y", int'(fy), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
